// File: rtl/fa_unpack.sv
// Frame-to-stream unpacker: a toggle-strobed packed frame is replayed as one
// AXI-Stream beat per channel, with a one-deep pending buffer and drop accounting.
module fa_unpack #(
  parameter int DATA_WIDTH    = 24,
  parameter int CHANNEL_WIDTH = 2,
  parameter int LAST_CHAN     = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                inputToggle,
  input  logic [(LAST_CHAN+1)*DATA_WIDTH-1:0] inputData,
  output logic [DATA_WIDTH-1:0]               M_TDATA,
  output logic [CHANNEL_WIDTH-1:0]            M_TCHANNEL,
  output logic                                M_TVALID,
  input  logic                                M_TREADY,
  output logic                                M_TLAST,
  output logic                                overrun,
  input  logic                                overrunClear,
  output logic [15:0]                         frameCount,
  output logic [15:0]                         dropCount
);

  localparam int FRAME_W = (LAST_CHAN + 1) * DATA_WIDTH;
  localparam logic [CHANNEL_WIDTH-1:0] LAST_IDX = CHANNEL_WIDTH'(LAST_CHAN);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                     state_q, state_d;
  logic                       toggle_q;
  logic [FRAME_W-1:0]         shadow_q, shadow_d;
  logic [FRAME_W-1:0]         pending_q, pending_d;
  logic                       shadow_full_q, shadow_full_d;
  logic                       pend_full_q, pend_full_d;
  logic [CHANNEL_WIDTH-1:0]   chan_q, chan_d;
  logic                       overrun_q, overrun_d;
  logic [15:0]                frame_cnt_q, frame_cnt_d;
  logic [15:0]                drop_cnt_q, drop_cnt_d;

  logic new_frame;
  logic hs;
  logic last_hs;
  logic accept;
  logic drop;

  assign new_frame = inputToggle ^ toggle_q;
  assign hs        = shadow_full_q && M_TREADY;
  assign last_hs   = hs && (chan_q == LAST_IDX);

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q;
    shadow_full_d = shadow_full_q;
    pend_full_d   = pend_full_q;
    chan_d        = chan_q;
    accept        = 1'b0;
    drop          = 1'b0;

    case (state_q)
      IDLE: begin
        if (new_frame) begin
          shadow_d      = inputData;
          shadow_full_d = 1'b1;
          chan_d        = '0;
          state_d       = SEND;
          accept        = 1'b1;
        end
      end
      SEND: begin
        if (last_hs) begin
          chan_d = '0;
          if (pend_full_q) begin
            // Pending promotes to shadow; a coincident frame refills pending.
            shadow_d = pending_q;
            if (new_frame) begin
              pending_d = inputData;
              accept    = 1'b1;
            end else begin
              pend_full_d = 1'b0;
            end
          end else if (new_frame) begin
            shadow_d = inputData;
            accept   = 1'b1;
          end else begin
            shadow_full_d = 1'b0;
            state_d       = IDLE;
          end
        end else begin
          if (hs) begin
            chan_d = chan_q + 1'b1;
          end
          if (new_frame) begin
            if (!pend_full_q) begin
              pending_d   = inputData;
              pend_full_d = 1'b1;
              accept      = 1'b1;
            end else begin
              drop = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    frame_cnt_d = frame_cnt_q + 16'(accept);
    drop_cnt_d  = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;

    // A drop in the same cycle as a clear request keeps the flag set.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (overrunClear) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk) begin
    toggle_q <= inputToggle;
    if (reset) begin
      state_q       <= IDLE;
      shadow_q      <= '0;
      pending_q     <= '0;
      shadow_full_q <= 1'b0;
      pend_full_q   <= 1'b0;
      chan_q        <= '0;
      overrun_q     <= 1'b0;
      frame_cnt_q   <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      shadow_full_q <= shadow_full_d;
      pend_full_q   <= pend_full_d;
      chan_q        <= chan_d;
      overrun_q     <= overrun_d;
      frame_cnt_q   <= frame_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign M_TVALID   = shadow_full_q;
  assign M_TCHANNEL = chan_q;
  assign M_TLAST    = shadow_full_q && (chan_q == LAST_IDX);
  assign M_TDATA    = shadow_full_q ? shadow_q[chan_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign overrun    = overrun_q;
  assign frameCount = frame_cnt_q;
  assign dropCount  = drop_cnt_q;

endmodule

// File: tb/tb_fa_unpack.sv
// Bench for fa_unpack: scoreboard of expected beats checked by a negedge monitor,
// a table of back-to-back frames, and directed stall/overrun/reset sequences.
module tb_fa_unpack;
  localparam int DW = 24;
  localparam int CW = 2;
  localparam int LC = 3;
  localparam int FW = (LC + 1) * DW;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] chan;
    logic          last;
  } beat_t;

  typedef struct {
    logic [FW-1:0] data;
    logic [15:0]   exp_fc;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          inputToggle;
  logic [FW-1:0] inputData;
  logic [DW-1:0] M_TDATA;
  logic [CW-1:0] M_TCHANNEL;
  logic          M_TVALID;
  logic          M_TREADY;
  logic          M_TLAST;
  logic          overrun;
  logic          overrunClear;
  logic [15:0]   frameCount;
  logic [15:0]   dropCount;

  fa_unpack #(.DATA_WIDTH(DW), .CHANNEL_WIDTH(CW), .LAST_CHAN(LC)) dut (
    .clk(clk), .reset(reset), .inputToggle(inputToggle), .inputData(inputData),
    .M_TDATA(M_TDATA), .M_TCHANNEL(M_TCHANNEL), .M_TVALID(M_TVALID),
    .M_TREADY(M_TREADY), .M_TLAST(M_TLAST), .overrun(overrun),
    .overrunClear(overrunClear), .frameCount(frameCount), .dropCount(dropCount)
  );

  always #5 clk = ~clk;

  int    tests = 0;
  int    fails = 0;
  int    exp_fc = 0;
  int    exp_dc = 0;
  beat_t sb[$];
  vec_t  vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                                       input logic [DW-1:0] c2, input logic [DW-1:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic push_frame(input logic [FW-1:0] f);
    beat_t b;
    for (int i = 0; i <= LC; i++) begin
      b.data = f[i*DW +: DW];
      b.chan = CW'(i);
      b.last = (i == LC);
      sb.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [FW-1:0] f, input bit deliver);
    inputData   = f;
    inputToggle = ~inputToggle;
    if (deliver) begin
      push_frame(f);
      exp_fc++;
    end
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !M_TVALID) done = 1'b1;
    end
    check({name, "_drain"}, 32'(done), 32'd1);
  endtask

  // Monitor: compare accepted beats against the scoreboard, and check that
  // stalled beats stay frozen until accepted.
  bit    held = 1'b0;
  beat_t held_b;
  always @(negedge clk) begin
    beat_t b;
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_stable", {1'b1, M_TVALID, M_TLAST, M_TCHANNEL, M_TDATA},
              {1'b1, 1'b1, held_b.last, held_b.chan, held_b.data});
      end
      if (M_TVALID && M_TREADY) begin
        $display("[TB] beat ch=%0d data=%0h last=%0b", M_TCHANNEL, M_TDATA, M_TLAST);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_beat: got ch=%0d data=%0h expected none",
                   M_TCHANNEL, M_TDATA);
        end else begin
          b = sb.pop_front();
          check("beat", {M_TLAST, M_TCHANNEL, M_TDATA}, {b.last, b.chan, b.data});
        end
      end
      held         = M_TVALID && !M_TREADY;
      held_b.data  = M_TDATA;
      held_b.chan  = M_TCHANNEL;
      held_b.last  = M_TLAST;
    end
  end

  initial begin
    logic [FW-1:0] fa, fb, fc;
    beat_t         b;

    vecs[0] = '{mk(24'h000000, 24'h000000, 24'h000000, 24'h000000), 16'd2};
    vecs[1] = '{mk(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF), 16'd3};
    vecs[2] = '{mk(24'hA5A5A5, 24'h5A5A5A, 24'hC3C3C3, 24'h3C3C3C), 16'd4};
    vecs[3] = '{mk(24'h123456, 24'h789ABC, 24'hDEF012, 24'h800001), 16'd5};

    reset        = 1'b1;
    inputToggle  = 1'b0;
    inputData    = '0;
    M_TREADY     = 1'b1;
    overrunClear = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(M_TVALID), 0);
    check("rst_last", 32'(M_TLAST), 0);
    check("rst_chan", 32'(M_TCHANNEL), 0);
    check("rst_data", 32'(M_TDATA), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_counts", {frameCount, dropCount}, 0);

    // Basic frame with one-cycle latency
    fa = mk(24'd1, 24'd2, 24'd3, 24'd4);
    tick();
    send(fa, 1);
    @(negedge clk);
    check("lat_pre_valid", 32'(M_TVALID), 0);
    @(negedge clk);
    check("lat_valid", 32'(M_TVALID), 1);
    check("lat_ch0", {M_TCHANNEL, M_TDATA}, {2'd0, 24'd1});
    drain("basic");
    check("basic_fc", 32'(frameCount), 1);

    for (int i = 0; i < 4; i++) begin
      tick();
      send(vecs[i].data, 1);
      drain("table");
      check("table_fc", 32'(frameCount), 32'(vecs[i].exp_fc));
      check("table_idle", 32'(M_TVALID), 0);
    end

    // Stall for five cycles on channel 2
    tick();
    send(fa, 1);
    tick();
    tick();
    tick();
    M_TREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", {M_TVALID, M_TCHANNEL, M_TDATA}, {1'b1, 2'd2, 24'd3});
      tick();
    end
    M_TREADY = 1'b1;
    drain("stall");
    check("stall_fc", 32'(frameCount), 32'(exp_fc));

    // Three frames back to back while stalled: third dropped
    fa = mk(24'h10, 24'h11, 24'h12, 24'h13);
    fb = mk(24'h20, 24'h21, 24'h22, 24'h23);
    fc = mk(24'h30, 24'h31, 24'h32, 24'h33);
    M_TREADY = 1'b0;
    tick(); send(fa, 1);
    tick(); send(fb, 1);
    tick(); send(fc, 0); exp_dc++;
    tick();
    @(negedge clk);
    check("drop_overrun", 32'(overrun), 1);
    check("drop_dc", 32'(dropCount), 32'(exp_dc));
    check("drop_fc", 32'(frameCount), 32'(exp_fc));
    M_TREADY = 1'b1;
    drain("drop");

    // Clear alone, then clear colliding with a drop
    tick(); overrunClear = 1'b1;
    tick(); overrunClear = 1'b0;
    @(negedge clk);
    check("clr_alone", 32'(overrun), 0);
    M_TREADY = 1'b0;
    tick(); send(fa, 1);
    tick(); send(fb, 1);
    tick(); send(fc, 0); exp_dc++; overrunClear = 1'b1;
    tick();
    @(negedge clk);
    check("clr_vs_drop", 32'(overrun), 1);
    check("clr_dc", 32'(dropCount), 32'(exp_dc));
    tick(); overrunClear = 1'b0;
    @(negedge clk);
    check("clr_next", 32'(overrun), 0);
    M_TREADY = 1'b1;
    drain("clr");

    // New frame coinciding with the last-beat handshake, pending empty
    tick(); send(fa, 1);
    tick(); tick(); tick(); tick();
    send(fb, 1);
    @(negedge clk);
    check("coin_last", {M_TLAST, M_TCHANNEL}, {1'b1, 2'd3});
    @(negedge clk);
    check("coin_next", {M_TVALID, M_TCHANNEL, M_TDATA}, {1'b1, 2'd0, 24'h20});
    check("coin_overrun", 32'(overrun), 0);
    drain("coin");
    check("coin_fc", 32'(frameCount), 32'(exp_fc));

    // Reset at channel 1 with pending full
    tick();
    inputData   = fa;
    inputToggle = ~inputToggle;
    b.data = 24'h10; b.chan = 2'd0; b.last = 1'b0;
    sb.push_back(b);
    tick();
    inputData   = fb;
    inputToggle = ~inputToggle;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("prerst_ch1", {M_TVALID, M_TCHANNEL}, {1'b1, 2'd1});
    tick();
    inputToggle = ~inputToggle;
    @(negedge clk);
    check("midrst_valid", 32'(M_TVALID), 0);
    check("midrst_counts", {frameCount, dropCount}, 0);
    tick();
    reset  = 1'b0;
    exp_fc = 0;
    exp_dc = 0;
    check("midrst_sb", 32'(sb.size()), 0);
    sb.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("postrst_idle", 32'(M_TVALID), 0);
    end
    check("postrst_fc", 32'(frameCount), 0);
    tick();
    send(fc, 1);
    drain("fresh");
    check("fresh_fc", 32'(frameCount), 1);
    check("fresh_dc", 32'(dropCount), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
